// File: rtl/sm2201_isa_cycle_controller.sv
// ISA I/O cycle sequencer for the SM2201 interface board: decodes the 16-register
// window, strobes the datapath once per command and owns isa_chrdy wait-state insertion.
module sm2201_isa_cycle_controller #(
  parameter logic [9:0] BASE_ADDR = 10'h300,
  parameter int         MIN_WAIT  = 2,
  parameter int         TIMEOUT   = 32
) (
  input  logic       isa_clk,
  input  logic       isa_reset,
  input  logic       isa_ior,
  input  logic       isa_iow,
  input  logic       isa_aen,
  input  logic [9:0] isa_addr,
  input  logic       dev_ack,
  input  logic       tmo_clr,
  output logic       isa_chrdy,
  output logic [3:0] reg_sel,
  output logic       rd_strobe,
  output logic       wr_strobe,
  output logic       busy,
  output logic       timeout_flag
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] ACK_MIN  = CNT_W'(MIN_WAIT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dir_rd_reg, dir_rd_next;
  logic [3:0]       reg_sel_reg, reg_sel_next;
  logic             tmo_reg, tmo_next;

  logic hit;
  logic cmd_gone;
  logic ack_ok;
  logic tmo_set;

  // Both commands low at once is a bus fault, so XOR rejects it as well as idle.
  assign hit      = (isa_ior ^ isa_iow) & ~isa_aen & (isa_addr[9:4] == BASE_ADDR[9:4]);
  assign cmd_gone = dir_rd_reg ? isa_ior : isa_iow;
  assign ack_ok   = dev_ack & (cnt_reg >= ACK_MIN);

  always_ff @(posedge isa_clk or negedge isa_reset) begin
    if (!isa_reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      dir_rd_reg  <= 1'b0;
      reg_sel_reg <= 4'd0;
      tmo_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dir_rd_reg  <= dir_rd_next;
      reg_sel_reg <= reg_sel_next;
      tmo_reg     <= tmo_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    dir_rd_next  = dir_rd_reg;
    reg_sel_next = reg_sel_reg;
    tmo_set      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (hit) begin
          state_next   = S_START;
          reg_sel_next = isa_addr[3:0];
          dir_rd_next  = ~isa_ior;
        end
      end
      S_START: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cmd_gone) begin
          state_next = S_IDLE;
        end else if (ack_ok) begin
          state_next = S_DONE;
        end else if (cnt_reg == TMO_LAST) begin
          state_next = S_DONE;
          tmo_set    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Waiting for full command release keeps one strobe per command assertion.
        if (isa_ior & isa_iow) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    tmo_next = tmo_set ? 1'b1 : (tmo_clr ? 1'b0 : tmo_reg);
  end

  assign isa_chrdy    = ~((state_reg == S_START) | (state_reg == S_WAIT));
  assign rd_strobe    = (state_reg == S_START) & dir_rd_reg;
  assign wr_strobe    = (state_reg == S_START) & ~dir_rd_reg;
  assign busy         = (state_reg != S_IDLE);
  assign reg_sel      = reg_sel_reg;
  assign timeout_flag = tmo_reg;

endmodule

// File: tb/tb_sm2201_isa_cycle_controller.sv
// Randomized bench for sm2201_isa_cycle_controller; expected waveforms are derived
// per transaction from the cycle-timing rules (strobe, wait length, abort, timeout).
module tb_sm2201_isa_cycle_controller;

  localparam logic [9:0] BASE_ADDR = 10'h300;
  localparam int         MIN_WAIT  = 2;
  localparam int         TIMEOUT   = 32;
  localparam int         NEVER     = 1000;

  logic       isa_clk = 1'b0;
  logic       isa_reset;
  logic       isa_ior;
  logic       isa_iow;
  logic       isa_aen;
  logic [9:0] isa_addr;
  logic       dev_ack;
  logic       tmo_clr;
  logic       isa_chrdy;
  logic [3:0] reg_sel;
  logic       rd_strobe;
  logic       wr_strobe;
  logic       busy;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;
  int txn_no = 0;

  logic       model_flag;
  logic [3:0] model_regsel;

  always #5 isa_clk = ~isa_clk;

  sm2201_isa_cycle_controller #(
    .BASE_ADDR(BASE_ADDR),
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .isa_clk     (isa_clk),
    .isa_reset   (isa_reset),
    .isa_ior     (isa_ior),
    .isa_iow     (isa_iow),
    .isa_aen     (isa_aen),
    .isa_addr    (isa_addr),
    .dev_ack     (dev_ack),
    .tmo_clr     (tmo_clr),
    .isa_chrdy   (isa_chrdy),
    .reg_sel     (reg_sel),
    .rd_strobe   (rd_strobe),
    .wr_strobe   (wr_strobe),
    .busy        (busy),
    .timeout_flag(timeout_flag)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input logic e_chrdy, input logic e_rd,
                           input logic e_wr, input logic e_busy);
    check_val({tag, ".chrdy"}, 32'(isa_chrdy), 32'(e_chrdy));
    check_val({tag, ".rd"}, 32'(rd_strobe), 32'(e_rd));
    check_val({tag, ".wr"}, 32'(wr_strobe), 32'(e_wr));
    check_val({tag, ".busy"}, 32'(busy), 32'(e_busy));
    check_val({tag, ".regsel"}, 32'(reg_sel), 32'(model_regsel));
    check_val({tag, ".flag"}, 32'(timeout_flag), 32'(model_flag));
  endtask

  // cmd: 0 read, 1 write, 2 both low. ack_k: WAIT index from which dev_ack is
  // held (negative = already during START). abort_a: WAIT index at which the
  // command is released early (-1 = never). clr_at: cycle index of a tmo_clr pulse.
  task automatic run_txn(input logic [9:0] addr, input logic aen, input int cmd,
                         input int ack_k, input int abort_a, input int clr_at,
                         input int hold);
    bit   is_hit, aborted, timed_out, cmd_low;
    int   eff_k, nat_exit, j_exit, low_end, rel, p;
    is_hit    = (cmd != 2) && !aen && (addr[9:4] == BASE_ADDR[9:4]);
    eff_k     = (ack_k < 0) ? 0 : ack_k;
    nat_exit  = (eff_k > MIN_WAIT - 1) ? eff_k : MIN_WAIT - 1;
    timed_out = nat_exit > TIMEOUT - 1;
    if (timed_out) nat_exit = TIMEOUT - 1;
    aborted   = (abort_a >= 0) && (abort_a <= nat_exit);
    if (aborted) timed_out = 1'b0;
    j_exit    = aborted ? abort_a : nat_exit;
    low_end   = is_hit ? 2 + j_exit : 0;
    rel       = !is_hit ? 2 : (aborted ? 2 + abort_a : 3 + j_exit + hold);
    txn_no++;
    $display("txn %0d addr=%03h aen=%0d cmd=%0d ack_k=%0d abort=%0d clr=%0d hit=%0d wait=%0d tmo=%0d",
             txn_no, addr, aen, cmd, ack_k, abort_a, clr_at, is_hit, j_exit + 1, timed_out);
    for (int m = 0; m <= rel; m++) begin
      cmd_low  = (m < rel);
      isa_addr = addr;
      isa_aen  = aen;
      isa_ior  = !(cmd_low && cmd != 1);
      isa_iow  = !(cmd_low && cmd != 0);
      dev_ack  = is_hit && (m >= ack_k + 2) && (m < rel);
      tmo_clr  = (m == clr_at);
      @(posedge isa_clk);
      #1;
      p = m + 1;
      if (is_hit && timed_out && p == j_exit + 3) model_flag = 1'b1;
      else if (m == clr_at) model_flag = 1'b0;
      if (is_hit && p == 1) model_regsel = addr[3:0];
      check_obs($sformatf("t%0d.p%0d", txn_no, p),
                !(is_hit && p <= low_end),
                is_hit && p == 1 && cmd == 0,
                is_hit && p == 1 && cmd == 1,
                is_hit && p <= rel);
    end
    dev_ack = 1'b0;
    tmo_clr = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    bit clr;
    for (int i = 0; i < n; i++) begin
      isa_ior  = 1'b1;
      isa_iow  = 1'b1;
      dev_ack  = 1'($urandom_range(0, 1));
      isa_aen  = 1'($urandom_range(0, 1));
      isa_addr = 10'($urandom);
      clr      = ($urandom_range(0, 3) == 0);
      tmo_clr  = clr;
      @(posedge isa_clk);
      #1;
      if (clr) model_flag = 1'b0;
      check_obs("idle", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    dev_ack = 1'b0;
    tmo_clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] r_addr;
    logic       r_aen;
    int         r_cmd, r_k, r_ab, r_clr;

    isa_reset = 1'b0;
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    isa_aen = 1'b0;
    isa_addr = 10'h000;
    dev_ack = 1'b0;
    tmo_clr = 1'b0;
    model_flag = 1'b0;
    model_regsel = 4'd0;
    #12;
    check_obs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge isa_clk);
    #3 isa_reset = 1'b1;

    // prompt-ack read, slow-ack write
    run_txn(10'h305, 1'b0, 0, -1, -1, -1, 1);
    idle_gap(2);
    run_txn(10'h30F, 1'b0, 1, 9, -1, -1, 0);
    idle_gap(1);

    // timeout, clear, timeout with coincident clear, flag survives a good cycle
    run_txn(10'h300, 1'b0, 0, NEVER, -1, -1, 0);
    run_txn(10'h310, 1'b0, 0, NEVER, -1, 1, 0);
    run_txn(10'h300, 1'b0, 0, NEVER, -1, TIMEOUT + 1, 0);
    run_txn(10'h301, 1'b0, 1, 0, -1, -1, 0);

    // filters
    run_txn(10'h310, 1'b0, 0, 0, -1, -1, 0);
    run_txn(10'h302, 1'b1, 0, 0, -1, -1, 0);
    run_txn(10'h302, 1'b0, 2, 0, -1, -1, 0);

    // abort on 2nd WAIT cycle, then a normal hit
    run_txn(10'h30A, 1'b0, 0, NEVER, 1, -1, 0);
    run_txn(10'h30B, 1'b0, 0, 3, -1, -1, 0);

    // asynchronous reset during WAIT, command held through reset release
    isa_addr = 10'h307;
    isa_aen = 1'b0;
    isa_ior = 1'b0;
    isa_iow = 1'b1;
    dev_ack = 1'b0;
    tmo_clr = 1'b0;
    repeat (3) @(posedge isa_clk);
    #1;
    model_regsel = 4'h7;
    check_obs("rst_pre", 1'b0, 1'b0, 1'b0, 1'b1);
    #2 isa_reset = 1'b0;
    #1;
    model_flag = 1'b0;
    model_regsel = 4'd0;
    check_obs("rst_async", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge isa_clk);
    #3 isa_reset = 1'b1;
    run_txn(10'h307, 1'b0, 0, 0, -1, -1, 1);

    // randomized traffic
    for (int i = 0; i < 50; i++) begin
      r_addr = ($urandom_range(0, 4) == 0) ? 10'($urandom)
                                           : {BASE_ADDR[9:4], 4'($urandom_range(0, 15))};
      r_aen  = ($urandom_range(0, 7) == 0);
      r_cmd  = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      r_k    = int'($urandom_range(0, 42)) - 2;
      r_ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
      r_clr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 36)) : -1;
      run_txn(r_addr, r_aen, r_cmd, r_k, r_ab, r_clr, int'($urandom_range(0, 2)));
      idle_gap(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sm2201_isa_cycle_controller.md
Name: sm2201_isa_cycle_controller

Overview:
Sequencer between the ISA slot and the SM2201 register/CAMAC datapath. It decodes ISA I/O read/write cycles in the board's 16-register window and issues a one-cycle strobe to the datapath. It holds isa_chrdy low until the datapath acknowledges or a timeout expires, then releases the bus and waits for the command to end. It is the single owner of isa_chrdy on the interface board.

Parameters:
BASE_ADDR, 10'h300, I/O base; the window is BASE_ADDR[9:4], 16 registers.
MIN_WAIT, 2, minimum isa_clk cycles in WAIT before an ack is honoured; legal range 1..TIMEOUT-1.
TIMEOUT, 32, WAIT cycles before a forced completion; legal range >= 2.

Ports:
isa_clk  in  1  bus clock; all state updates on the rising edge.
isa_reset  in  1  asynchronous reset, active-low.
isa_ior  in  1  ISA I/O read command, active-low.
isa_iow  in  1  ISA I/O write command, active-low.
isa_aen  in  1  DMA address enable; high means ignore the cycle.
isa_addr  in  10  ISA I/O address.
dev_ack  in  1  datapath has completed the access (level).
tmo_clr  in  1  one-cycle pulse that clears timeout_flag.
isa_chrdy  out  1  channel ready; 0 inserts wait states.
reg_sel  out  4  latched register index, isa_addr[3:0].
rd_strobe  out  1  one-cycle read request to the datapath.
wr_strobe  out  1  one-cycle write request to the datapath.
busy  out  1  high whenever the state is not IDLE.
timeout_flag  out  1  sticky; set when a cycle completes by timeout.

Behaviour:
- Reset (isa_reset=0, asynchronous): state=IDLE, isa_chrdy=1, reg_sel=0, rd_strobe=0, wr_strobe=0, busy=0, timeout_flag=0, wait counter=0.
- hit = (isa_ior ^ isa_iow) & ~isa_aen & (isa_addr[9:4]==BASE_ADDR[9:4]).
  - If isa_ior and isa_iow are both low, the cycle is never a hit.
- IDLE: on hit, go to START. In the same edge, latch reg_sel=isa_addr[3:0], latch dir (read if isa_ior=0), and drive isa_chrdy=0.
- START: lasts 1 cycle. rd_strobe or wr_strobe=1 according to dir. Counter=0. Go to WAIT.
- WAIT: counter increments by 1 each cycle. isa_chrdy stays 0. Transitions, in priority order:
  1. The latched command (isa_ior for a read, isa_iow for a write) is high: abort. Go to IDLE, isa_chrdy=1, no flag.
  2. dev_ack=1 and counter >= MIN_WAIT-1: go to DONE.
  3. counter == TIMEOUT-1: go to DONE and set timeout_flag.
- DONE: isa_chrdy=1. Stay until isa_ior and isa_iow are both high, then go to IDLE.
  - A new hit is not accepted in DONE, so one command assertion yields exactly one strobe.
- Latency: hit sampled at edge N -> strobe high during N+1 -> earliest isa_chrdy=1 at edge N+1+MIN_WAIT.
- A dev_ack that arrives before MIN_WAIT is held off until the minimum is met. An ack asserted during START is ignored.
- Counter width: clog2(TIMEOUT). No wrap is possible because TIMEOUT-1 forces exit.
- timeout_flag: tmo_clr clears it. If a set and a clear happen in the same cycle, set wins. The flag survives later successful cycles.
- reg_sel holds its value outside a cycle.
- Strobes are exactly one cycle wide and never both high.
- busy = (state != IDLE).

Test Plan:
1. Read, prompt ack. Reset, then isa_addr=10'h305, aen=0, ior=0. dev_ack is held 1 from the first WAIT cycle. Expect reg_sel=5, rd_strobe one cycle, chrdy low for exactly 1+MIN_WAIT=3 edges then high. After ior rises, busy=0.
2. Write, slow ack. isa_addr=10'h30F, iow=0, dev_ack raised on the 10th WAIT cycle. Expect one wr_strobe, chrdy low until the cycle after the ack, timeout_flag=0.
3. Timeout. Read at 10'h300 with dev_ack never asserted. Expect chrdy released after TIMEOUT=32 WAIT cycles and timeout_flag=1. A tmo_clr pulse returns the flag to 0. Repeat with tmo_clr coinciding with the timeout edge: flag remains 1.
4. Filters, each producing no strobe and chrdy steady at 1:
   - isa_addr=10'h310;
   - aen=1 at 10'h302;
   - ior=iow=0 at 10'h302.
5. Abort. Read hit, then ior raised on the 2nd WAIT cycle. Expect immediate return to IDLE, chrdy=1, no flag, and a following hit served normally.
6. Reset mid-cycle. Pull isa_reset low during WAIT. Expect chrdy=1, busy=0 and strobes 0 asynchronously. Holding ior low after reset release yields a fresh START.
